sdram_port_scheduler: RTL and testbench
=======================================

# sdram_port_scheduler

Four-port burst scheduler for the SDRAM controller. Tracks per-port burst address, length and wrap limit for two read ports and two write ports, and picks which port gets the next SDRAM page burst based on FIFO fill levels. It issues one burst request at a time to the SDRAM command engine and steers that engine's FIFO handshakes through a one-hot grant.

## Interface
- ASIZE, 23, SDRAM word address width
- LEN_W, 9, burst length width
- LVL_W, 16, FIFO level width
- CLK  in  1  controller clock; all logic on its rising edge
- RESET_N  in  1  synchronous, active-low reset
- LOAD  in  4  per-port register load; bit 0=RD1, 1=RD2, 2=WR1, 3=WR2
- START_ADDR  in  4*ASIZE  per-port start address, also the wrap target
- MAX_ADDR  in  4*ASIZE  per-port wrap limit
- LENGTH  in  4*LEN_W  per-port burst length
- LEVEL  in  4*LVL_W  read ports: read-FIFO write-side used words; write ports: write-FIFO read-side used words
- REQ_VALID  out  1  burst request pending
- REQ_READY  in  1  command engine accepts request
- REQ_WRITE  out  1  1 = write burst
- REQ_ADDR  out  ASIZE  burst start address
- REQ_LEN  out  LEN_W  burst length
- REQ_PORT  out  2  granted port index
- DONE  in  1  one-cycle burst-complete pulse from command engine
- GRANT_MASK  out  4  one-hot granted port, for FIFO rdreq/wrreq steering
- BUSY  out  1  high whenever state is not IDLE

## Operation
- Per-port registers: addr, max, len. A LOAD bit copies START_ADDR, MAX_ADDR and LENGTH for its port. LOAD takes priority over the address advance in the same cycle.
- Eligibility is evaluated only in IDLE.
  - Read port: len != 0 and LEVEL < len.
  - Write port: len != 0 and LEVEL >= len.
- No grant is made in any cycle where any LOAD bit is high.
- States:
  - IDLE: if at least one port is eligible, latch the chosen port, drive REQ_* and GRANT_MASK, go to ISSUE.
  - ISSUE: hold REQ_VALID until REQ_VALID & REQ_READY, then go to WAIT_DONE.
  - WAIT_DONE: wait for DONE, then go to UPDATE.
  - UPDATE: advance the granted port's addr, clear the grant, go to IDLE.
- Address advance uses ASIZE+1-bit arithmetic. If addr < max - len, addr <= addr + len; otherwise addr <= START_ADDR (the input value). If max < len, the port always wraps.
- Arbitration is round-robin over the eligible ports, starting at the index after the last grant. Reset pointer = 3, so port 0 has first priority.
- REQ_ADDR, REQ_LEN, REQ_WRITE and REQ_PORT are stable from ISSUE entry until UPDATE exits. A LOAD during a burst does not change the in-flight request.
- DONE outside WAIT_DONE is ignored. REQ_READY outside ISSUE is ignored.
- Reset values: REQ_VALID=0, REQ_WRITE=0, REQ_ADDR=0, REQ_LEN=0, REQ_PORT=0, GRANT_MASK=0, BUSY=0. All addr/max/len registers = 0, which leaves every port ineligible until it is loaded. State = IDLE.
- Reset mid-burst aborts immediately with no address update. Any DONE that arrives afterwards is ignored.

## Timing
- Eligible in IDLE at cycle N: REQ_VALID, GRANT_MASK and BUSY go high at N+1.
- Handshake: REQ_VALID falls the cycle after REQ_VALID & REQ_READY.
- DONE at cycle M: UPDATE at M+1, IDLE at M+2 with the new addr visible. The next grant is possible at M+3.
- Minimum turnaround between grants is 4 cycles plus command-engine latency.
- LEVEL and LENGTH are assumed synchronous to CLK. Clock-domain crossing is handled in the FIFOs.

## Configuration
- SCHED_RD_PRIORITY_EN defined: any eligible read port beats every write port. Round-robin applies within the read pair and within the write pair, each with its own pointer.
- SCHED_RD_PRIORITY_EN undefined: a single 4-way round-robin across all ports.

## Structure
- Package sdram_sched_pkg holds:
  - port index constants (RD1, RD2, WR1, WR2)
  - the state enum (IDLE, ISSUE, WAIT_DONE, UPDATE)
  - default widths
- Sub-module sdram_rr_pick: combinational 4-bit round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and index. It is instanced twice (2-bit use) under SCHED_RD_PRIORITY_EN.

## Test plan
- Reset, then LOAD port 0 (start 0x100, max 0x400, len 128) with LEVEL0=0 -> REQ_VALID one cycle after IDLE, REQ_WRITE=0, REQ_ADDR=0x100, REQ_LEN=128, GRANT_MASK=0001.
- Repeated port-0 bursts with DONE -> REQ_ADDR sequence 0x100, 0x180, 0x200, 0x280, 0x300, 0x380, then wraps to 0x100.
- All four ports eligible, each burst acknowledged -> macro off: grant order 0,1,2,3,0. Macro on: 0,1,0,1, with no write grant while reads stay eligible.
- Write port with LENGTH=0 and LEVEL=500 -> never granted. Read port with LEVEL >= len -> never granted.
- LOAD port 2 (start 0x2000) during WAIT_DONE of port 2 -> REQ_ADDR unchanged until DONE. After UPDATE, port 2 addr = 0x2000, not advanced. No grant while LOAD is high.
- RESET_N low in WAIT_DONE -> next cycle REQ_VALID=0, GRANT_MASK=0, BUSY=0. A later DONE pulse produces no state change.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared widths, port indices and FSM states for sdram_port_scheduler.
package sdram_sched_pkg;
  localparam int ASIZE = 23;
  localparam int LEN_W = 9;
  localparam int LVL_W = 16;
  localparam logic [1:0] RD1 = 2'd0;
  localparam logic [1:0] RD2 = 2'd1;
  localparam logic [1:0] WR1 = 2'd2;
  localparam logic [1:0] WR2 = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, UPDATE} state_t;
endpackage

// File: rtl/sdram_port_scheduler_if.sv
// sdram_port_scheduler_if: port configuration, FIFO levels and command-engine handshake.
// master: scheduler side (drives REQ_*, GRANT_MASK, BUSY).
// slave: host / command-engine side (drives LOAD, START_ADDR, MAX_ADDR, LENGTH, LEVEL, REQ_READY, DONE).
// Vectors are packed per port, port 0 (RD1) in the low slice, port 3 (WR2) in the high slice.
interface sdram_port_scheduler_if;
  import sdram_sched_pkg::*;
  logic [3:0]         LOAD;
  logic [4*ASIZE-1:0] START_ADDR;
  logic [4*ASIZE-1:0] MAX_ADDR;
  logic [4*LEN_W-1:0] LENGTH;
  logic [4*LVL_W-1:0] LEVEL;
  logic               REQ_VALID;
  logic               REQ_READY;
  logic               REQ_WRITE;
  logic [ASIZE-1:0]   REQ_ADDR;
  logic [LEN_W-1:0]   REQ_LEN;
  logic [1:0]         REQ_PORT;
  logic               DONE;
  logic [3:0]         GRANT_MASK;
  logic               BUSY;
  modport master (
    input  LOAD, START_ADDR, MAX_ADDR, LENGTH, LEVEL, REQ_READY, DONE,
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, REQ_PORT, GRANT_MASK, BUSY
  );
  modport slave (
    output LOAD, START_ADDR, MAX_ADDR, LENGTH, LEVEL, REQ_READY, DONE,
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, REQ_PORT, GRANT_MASK, BUSY
  );
endinterface

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: combinational 4-way round-robin picker.
// req: request vector; ptr: last granted index (search starts at ptr+1).
// gnt: one-hot grant (zero when no request); idx: granted index.
module sdram_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);
  // Scan from farthest to nearest so the nearest requester after ptr is written last.
  always_comb begin
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) idx = req[2'(ptr + 2'(k))] ? 2'(ptr + 2'(k)) : idx;
    gnt = |req ? 4'b0001 << idx : 4'b0000;
  end
endmodule

// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: four-port SDRAM page-burst scheduler (RD1, RD2, WR1, WR2).
// Ports: CLK, RESET_N (synchronous, active-low); bus (sdram_port_scheduler_if.master)
//   carrying per-port LOAD/START_ADDR/MAX_ADDR/LENGTH/LEVEL, the REQ_* handshake to the
//   command engine, DONE, one-hot GRANT_MASK and BUSY.
// Optional SCHED_RD_PRIORITY_EN: eligible reads always beat writes, with a separate
//   round-robin pointer per pair; otherwise a single 4-way round-robin.
module sdram_port_scheduler
  import sdram_sched_pkg::*;
(
  input logic                   CLK,
  input logic                   RESET_N,
  sdram_port_scheduler_if.master bus
);
  state_t           state_q, state_d;
  logic [ASIZE-1:0] addr_q [4];
  logic [ASIZE-1:0] addr_d [4];
  logic [ASIZE-1:0] max_q [4];
  logic [ASIZE-1:0] max_d [4];
  logic [LEN_W-1:0] len_q [4];
  logic [LEN_W-1:0] len_d [4];
  logic [ASIZE-1:0] req_addr_q, req_addr_d;
  logic [LEN_W-1:0] req_len_q, req_len_d;
  logic [1:0]       port_q, port_d;
  logic [3:0]       grant_q, grant_d;
  logic             reload_q, reload_d;
  logic [3:0]       elig, pick_gnt;
  logic [1:0]       pick_idx;
  logic             grant_ok;
  logic [ASIZE:0]   lim;
  logic [ASIZE-1:0] adv_addr;

  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++)
      elig[i] = len_q[i] != '0 && ((i < 2) ? bus.LEVEL[i*LVL_W +: LVL_W] < LVL_W'(len_q[i])
                                           : bus.LEVEL[i*LVL_W +: LVL_W] >= LVL_W'(len_q[i]));
  end

  assign grant_ok = state_q == IDLE && |elig && !(|bus.LOAD);

`ifdef SCHED_RD_PRIORITY_EN
  logic       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_gnt, wr_gnt;
  logic [1:0] rd_idx, wr_idx;
  sdram_rr_pick u_rd_pick (.req({2'b00, elig[1:0]}), .ptr({1'b0, rd_ptr_q}), .gnt(rd_gnt), .idx(rd_idx));
  sdram_rr_pick u_wr_pick (.req({2'b00, elig[3:2]}), .ptr({1'b0, wr_ptr_q}), .gnt(wr_gnt), .idx(wr_idx));
  assign pick_gnt = |elig[1:0] ? rd_gnt : {wr_gnt[1:0], 2'b00};
  assign pick_idx = |elig[1:0] ? rd_idx : {1'b1, wr_idx[0]};
  always_comb begin
    rd_ptr_d = grant_ok && !pick_idx[1] ? pick_idx[0] : rd_ptr_q;
    wr_ptr_d = grant_ok && pick_idx[1] ? pick_idx[0] : wr_ptr_q;
  end
  // Pointers start on the second port of each pair so RD1 and WR1 win first.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rd_ptr_q <= 1'b1;
      wr_ptr_q <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  sdram_rr_pick u_pick (.req(elig), .ptr(ptr_q), .gnt(pick_gnt), .idx(pick_idx));
  always_comb ptr_d = grant_ok ? pick_idx : ptr_q;
  always_ff @(posedge CLK) ptr_q <= !RESET_N ? WR2 : ptr_d;
`endif

  // Wrap test in ASIZE+1 bits: a negative max-len (max < len) forces a wrap.
  always_comb begin
    lim = {1'b0, max_q[port_q]} - (ASIZE+1)'(len_q[port_q]);
    adv_addr = (!lim[ASIZE] && {1'b0, addr_q[port_q]} < lim) ? addr_q[port_q] + ASIZE'(len_q[port_q])
                                                            : bus.START_ADDR[port_q*ASIZE +: ASIZE];
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    grant_d    = grant_q;
    req_addr_d = req_addr_q;
    req_len_d  = req_len_q;
    // A reload of the in-flight port cancels its post-burst advance.
    reload_d   = state_q == IDLE ? 1'b0 : reload_q | bus.LOAD[port_q];
    for (int i = 0; i < 4; i++) begin
      addr_d[i] = bus.LOAD[i] ? bus.START_ADDR[i*ASIZE +: ASIZE]
                : (state_q == UPDATE && port_q == 2'(i) && !reload_q) ? adv_addr : addr_q[i];
      max_d[i]  = bus.LOAD[i] ? bus.MAX_ADDR[i*ASIZE +: ASIZE] : max_q[i];
      len_d[i]  = bus.LOAD[i] ? bus.LENGTH[i*LEN_W +: LEN_W] : len_q[i];
    end
    case (state_q)
      IDLE: if (grant_ok) begin
        state_d    = ISSUE;
        port_d     = pick_idx;
        grant_d    = pick_gnt;
        req_addr_d = addr_q[pick_idx];
        req_len_d  = len_q[pick_idx];
      end
      ISSUE:     state_d = bus.REQ_READY ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_d = bus.DONE ? UPDATE : WAIT_DONE;
      UPDATE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      port_q     <= RD1;
      grant_q    <= '0;
      req_addr_q <= '0;
      req_len_q  <= '0;
      reload_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        max_q[i]  <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      grant_q    <= grant_d;
      req_addr_q <= req_addr_d;
      req_len_q  <= req_len_d;
      reload_q   <= reload_d;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= addr_d[i];
        max_q[i]  <= max_d[i];
        len_q[i]  <= len_d[i];
      end
    end
  end

  assign bus.REQ_VALID  = state_q == ISSUE;
  assign bus.REQ_WRITE  = port_q[1];
  assign bus.REQ_ADDR   = req_addr_q;
  assign bus.REQ_LEN    = req_len_q;
  assign bus.REQ_PORT   = port_q;
  assign bus.GRANT_MASK = grant_q;
  assign bus.BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// tb_sdram_port_scheduler: self-checking bench for sdram_port_scheduler (table, directed and random).
module tb_sdram_port_scheduler;
  import sdram_sched_pkg::*;

  typedef struct {int l0; int l1; int l2; int l3; int port;} vec_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  sdram_port_scheduler_if bus();
  sdram_port_scheduler dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  int total = 0;
  int bad = 0;
  int cur_lv[4];
  int m_start[4], m_max[4], m_len[4], m_addr[4];
  int m_ptr, m_rdp, m_wrp, m_port, m_exp_addr, m_exp_len;
  bit m_busy, m_reload;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_start[i] = 0; m_max[i] = 0; m_len[i] = 0; m_addr[i] = 0;
    end
    m_ptr = 3; m_rdp = 1; m_wrp = 3; m_busy = 0; m_reload = 0; m_port = 0;
  endtask

  function automatic bit m_elig(input int p);
    return m_len[p] != 0 && (p < 2 ? cur_lv[p] < m_len[p] : cur_lv[p] >= m_len[p]);
  endfunction

  function automatic int m_pick();
`ifdef SCHED_RD_PRIORITY_EN
    for (int k = 1; k <= 2; k++) if (m_elig((m_rdp + k) % 2)) return (m_rdp + k) % 2;
    for (int k = 1; k <= 2; k++) if (m_elig(2 + (m_wrp + k) % 2)) return 2 + (m_wrp + k) % 2;
`else
    for (int k = 1; k <= 4; k++) if (m_elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
`endif
    return -1;
  endfunction

  task automatic m_done();
    if (!m_reload)
      m_addr[m_port] = (m_addr[m_port] + m_len[m_port] < m_max[m_port]) ? m_addr[m_port] + m_len[m_port]
                                                                      : m_start[m_port];
    m_busy = 0;
  endtask

  task automatic set_lv(input int a, input int b, input int c, input int d);
    cur_lv = '{a, b, c, d};
    bus.LEVEL = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic load(input int p, input int s, input int m, input int l);
    bus.START_ADDR[p*ASIZE +: ASIZE] = ASIZE'(s);
    bus.MAX_ADDR[p*ASIZE +: ASIZE]   = ASIZE'(m);
    bus.LENGTH[p*LEN_W +: LEN_W]     = LEN_W'(l);
    bus.LOAD = 4'(1 << p);
    m_start[p] = s; m_max[p] = m; m_len[p] = l; m_addr[p] = s;
    if (m_busy && p == m_port) m_reload = 1;
    tick();
    bus.LOAD = '0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    bus.LOAD = '0; bus.REQ_READY = 1'b0; bus.DONE = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    m_reset();
  endtask

  task automatic grant(input string tag, output int p);
    p = m_pick();
    chk({tag, " valid"}, bus.REQ_VALID, 64'(p >= 0));
    if (p >= 0) begin
      chk({tag, " port"}, bus.REQ_PORT, p);
      chk({tag, " addr"}, bus.REQ_ADDR, m_addr[p]);
      chk({tag, " len"}, bus.REQ_LEN, m_len[p]);
      chk({tag, " write"}, bus.REQ_WRITE, 64'(p >= 2));
      chk({tag, " mask"}, bus.GRANT_MASK, 1 << p);
      chk({tag, " busy"}, bus.BUSY, 1);
      m_ptr = p;
      if (p < 2) m_rdp = p; else m_wrp = p;
      m_port = p; m_busy = 1; m_reload = 0;
      m_exp_addr = m_addr[p]; m_exp_len = m_len[p];
    end
  endtask

  // Stray DONE during ISSUE and stray REQ_READY during WAIT_DONE must be ignored.
  task automatic burst(input int rw, input int dw);
    for (int i = 0; i < rw; i++) begin
      bus.DONE = i == 0;
      tick();
    end
    bus.DONE = 1'b0;
    chk("valid held", bus.REQ_VALID, 1);
    bus.REQ_READY = 1'b1;
    tick();
    bus.REQ_READY = 1'b0;
    chk("valid drop", bus.REQ_VALID, 0);
    chk("busy wait", bus.BUSY, 1);
    for (int i = 0; i < dw; i++) begin
      bus.REQ_READY = i == 0;
      tick();
    end
    bus.REQ_READY = 1'b0;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("upd addr hold", bus.REQ_ADDR, m_exp_addr);
    chk("upd mask hold", bus.GRANT_MASK, 1 << m_port);
    tick();
    m_done();
    chk("idle busy", bus.BUSY, 0);
    chk("idle mask", bus.GRANT_MASK, 0);
  endtask

  initial begin
    vec_t tbl[13];
    int seq[7] = '{'h100, 'h180, 'h200, 'h280, 'h300, 'h380, 'h100};
`ifdef SCHED_RD_PRIORITY_EN
    int exp_port[13] = '{0, 1, 0, 1, 0, 2, 3, 1, -1, 2, -1, 0, 1};
`else
    int exp_port[13] = '{0, 1, 2, 3, 0, 2, 3, 1, -1, 2, -1, 0, 1};
`endif
    int p, act;
    tbl = '{'{0, 0, 500, 500, 0}, '{0, 0, 500, 500, 0}, '{0, 0, 500, 500, 0}, '{0, 0, 500, 500, 0},
            '{0, 0, 500, 500, 0}, '{500, 500, 500, 500, 0}, '{500, 500, 500, 500, 0},
            '{500, 0, 0, 0, 0}, '{500, 500, 0, 0, 0}, '{500, 500, 32, 0, 0},
            '{128, 500, 0, 0, 0}, '{127, 500, 0, 0, 0}, '{0, 0, 31, 15, 0}};
    for (int i = 0; i < 13; i++) tbl[i].port = exp_port[i];
    bus.LOAD = '0; bus.START_ADDR = '0; bus.MAX_ADDR = '0; bus.LENGTH = '0;
    bus.REQ_READY = 1'b0; bus.DONE = 1'b0;
    set_lv(0, 0, 0, 0);
    do_reset();
    chk("rst valid", bus.REQ_VALID, 0);
    chk("rst write", bus.REQ_WRITE, 0);
    chk("rst addr", bus.REQ_ADDR, 0);
    chk("rst len", bus.REQ_LEN, 0);
    chk("rst port", bus.REQ_PORT, 0);
    chk("rst mask", bus.GRANT_MASK, 0);
    chk("rst busy", bus.BUSY, 0);

    // Port 0 alone, WR1 unloaded with a full FIFO: address walk and wrap.
    set_lv(0, 0, 500, 0);
    load(0, 'h100, 'h400, 128);
    chk("load blocks grant", bus.REQ_VALID, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      grant("seq", p);
      chk("seq addr", bus.REQ_ADDR, seq[i]);
      burst(i % 3, i % 2);
    end

    // Arbitration table with all four ports configured.
    do_reset();
    set_lv(500, 500, 0, 0);
    load(0, 'h100, 'h400, 128);
    load(1, 'h1000, 'h1800, 64);
    load(2, 'h2000, 'h2400, 32);
    load(3, 'h3000, 'h3100, 16);
    chk("load blocks grant", bus.REQ_VALID, 0);
    for (int i = 0; i < 13; i++) begin
      set_lv(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3);
      tick();
      grant("tbl", p);
      act = bus.REQ_VALID ? int'(bus.REQ_PORT) : -1;
      chk("tbl order", act, tbl[i].port);
      if (p >= 0) burst(1, 1);
    end

    // Reload of port 2 while its burst is in WAIT_DONE.
    set_lv(500, 500, 500, 0);
    tick();
    grant("ld", p);
    chk("ld port", bus.REQ_PORT, 2);
    bus.REQ_READY = 1'b1;
    tick();
    bus.REQ_READY = 1'b0;
    set_lv(500, 500, 0, 0);
    load(2, 'h2000, 'h2400, 32);
    chk("ld hold addr", bus.REQ_ADDR, m_exp_addr);
    chk("ld hold len", bus.REQ_LEN, m_exp_len);
    chk("ld busy", bus.BUSY, 1);
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("ld upd addr", bus.REQ_ADDR, m_exp_addr);
    tick();
    m_done();
    chk("ld idle", bus.BUSY, 0);
    set_lv(500, 500, 500, 0);
    load(2, 'h2000, 'h2400, 32);
    chk("load blocks grant", bus.REQ_VALID, 0);
    tick();
    grant("ld2", p);
    chk("ld reload addr", bus.REQ_ADDR, 'h2000);
    if (p >= 0) burst(0, 0);

    // Reset during WAIT_DONE, then a late DONE.
    tick();
    grant("rst2", p);
    bus.REQ_READY = 1'b1;
    tick();
    bus.REQ_READY = 1'b0;
    RESET_N = 1'b0;
    tick();
    chk("abort valid", bus.REQ_VALID, 0);
    chk("abort mask", bus.GRANT_MASK, 0);
    chk("abort busy", bus.BUSY, 0);
    chk("abort addr", bus.REQ_ADDR, 0);
    RESET_N = 1'b1;
    m_reset();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    tick();
    chk("late done busy", bus.BUSY, 0);
    chk("late done valid", bus.REQ_VALID, 0);

    // Randomized traffic against the reference model.
    set_lv(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int s = int'($urandom_range(0, 'h3ff));
      load(i, s, s + int'($urandom_range(0, 'h600)), int'($urandom_range(0, 300)));
    end
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s = int'($urandom_range(0, 'h3ff));
        load(int'($urandom_range(0, 3)), s, s + int'($urandom_range(0, 'h600)), int'($urandom_range(0, 300)));
        chk("rnd load blocks", bus.REQ_VALID, 0);
      end
      set_lv(int'($urandom_range(0, 600)), int'($urandom_range(0, 600)),
             int'($urandom_range(0, 600)), int'($urandom_range(0, 600)));
      tick();
      grant("rnd", p);
      if (p >= 0) burst(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
